// File: rtl/control_signal_unit.sv
// rtl/control_signal_unit.sv - inline control-point override driven by a serially loaded, trigger-armed config
module control_signal_unit #(
  parameter int CTRL_WIDTH = 8,
  parameter int HOLD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic                  cfg_bit,
  output logic                  cfg_ready,
  input  logic                  trigger,
  input  logic                  clear,
  input  logic [CTRL_WIDTH-1:0] sig_in,
  output logic [CTRL_WIDTH-1:0] sig_out,
  output logic                  active,
  output logic                  cfg_loaded
);

  localparam int FRAME_BITS = 2*CTRL_WIDTH + HOLD_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_OVERRIDE
  } state_t;

  state_t                  state, state_next;
  logic [FRAME_BITS-1:0]   shadow, shadow_next;
  logic [CTRL_WIDTH-1:0]   mask, value;
  logic [HOLD_WIDTH-1:0]   hold, hold_cnt;
  logic [CNT_W-1:0]        bit_cnt;

  logic accept;
  logic last_bit;
  logic do_commit;
  logic do_arm;
  logic do_dec;

  // A bit is consumed whenever it is offered and we are not mid-override
  assign cfg_ready  = (state != S_OVERRIDE);
  assign accept     = cfg_valid && cfg_ready;
  assign last_bit   = accept && (state == S_LOAD) && (bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign active     = (state == S_OVERRIDE);
  assign cfg_loaded = (state == S_ARMED) || (state == S_OVERRIDE);

  // Unmasked bits pass straight through; the async reset drops the override at once
  assign sig_out = active ? ((sig_in & ~mask) | (value & mask)) : sig_in;

  // Frame bit lands at its sequence position; the final bit is merged here so commit can use it
  always_comb begin
    shadow_next = shadow;
    shadow_next[bit_cnt] = cfg_bit;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control strobes; clear outranks cfg bits, which outrank trigger
  always_comb begin
    state_next = state;
    do_commit  = 1'b0;
    do_arm     = 1'b0;
    do_dec     = 1'b0;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) state_next = S_LOAD;
        end
        S_LOAD: begin
          if (last_bit) begin
            state_next = S_ARMED;
            do_commit  = 1'b1;
          end
        end
        S_ARMED: begin
          if (accept) begin
            state_next = S_LOAD;
          end else if (trigger) begin
            state_next = S_OVERRIDE;
            do_arm     = 1'b1;
          end
        end
        S_OVERRIDE: begin
          // hold of zero means the override sticks until clear or reset
          if (hold != '0) begin
            if (hold_cnt == HOLD_WIDTH'(1)) begin
              state_next = S_ARMED;
            end else begin
              do_dec = 1'b1;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Config shifting, commit and hold countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      mask     <= '0;
      value    <= '0;
      hold     <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
    end else if (clear) begin
      shadow   <= '0;
      mask     <= '0;
      value    <= '0;
      hold     <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      if (accept) begin
        shadow  <= shadow_next;
        bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      end
      if (do_commit) begin
        mask  <= shadow_next[CTRL_WIDTH-1:0];
        value <= shadow_next[2*CTRL_WIDTH-1:CTRL_WIDTH];
        hold  <= shadow_next[FRAME_BITS-1:2*CTRL_WIDTH];
      end
      if (do_arm) begin
        hold_cnt <= hold;
      end else if (do_dec) begin
        hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
      end
    end
  end

endmodule
